// File: rtl/mul_hi_sequencer_pkg.sv
// mul_hi_sequencer_pkg: op and state encodings, delay-line tag and magnitude helper
package mul_hi_sequencer_pkg;
  typedef enum logic [1:0] {OP_MUL, OP_MULXSS, OP_MULXSU, OP_MULXUU} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIX} state_e;
  typedef struct packed {
    logic       v;
    logic [1:0] idx;
  } tag_t;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/mul_hi_sequencer.sv
// mul_hi_sequencer: 32x32 multiply built from four 16x16 partial products via an external registered cell
module mul_hi_sequencer
  import mul_hi_sequencer_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        kill,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] cell_a,
  output logic [15:0] cell_b,
  input  logic [31:0] cell_p
);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, mag_a, mag_b, result_q, result_d;
  logic [63:0] acc_q, acc_d, acc_add, acc_fix;
  logic [15:0] cell_a_q, cell_a_d, cell_b_q, cell_b_d;
  logic [1:0]  idx_q, idx_d, nxt;
  logic [5:0]  shamt;
  logic        sign_q, sign_d, busy_q, busy_d, done_q, done_d, sa, sb;
  tag_t        dl_q [CELL_LATENCY];
  tag_t        dl_d [CELL_LATENCY];
  tag_t        dl_out;
  always_comb begin
    sa       = (op == OP_MULXSS || op == OP_MULXSU) && src1[31];
    sb       = (op == OP_MULXSS) && src2[31];
    mag_a    = mag(src1, sa);
    mag_b    = mag(src2, sb);
    dl_out   = dl_q[CELL_LATENCY-1];
    shamt    = dl_out.idx == 2'd0 ? 6'd0 : dl_out.idx == 2'd3 ? 6'd32 : 6'd16;
    acc_add  = acc_q + (dl_out.v ? {32'b0, cell_p} << shamt : 64'd0);
    acc_fix  = (sign_q && op_q != OP_MUL) ? -acc_q : acc_q;
    nxt      = idx_q + 2'd1;
    state_d  = state_q;
    op_d     = op_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = 1'b0;
    cell_a_d = 16'd0;
    cell_b_d = 16'd0;
    dl_d[0]  = '{v: state_q == ST_ISSUE, idx: idx_q};
    for (int i = 1; i < CELL_LATENCY; i++) dl_d[i] = dl_q[i-1];
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_ISSUE;
        op_d     = op_e'(op);
        ma_d     = mag_a;
        mb_d     = mag_b;
        sign_d   = sa ^ sb;
        acc_d    = 64'd0;
        idx_d    = 2'd0;
        cell_a_d = mag_a[15:0];
        cell_b_d = mag_b[15:0];
      end
      ST_ISSUE: begin
        acc_d    = acc_add;
        idx_d    = nxt;
        state_d  = idx_q == 2'd3 ? ST_DRAIN : ST_ISSUE;
        cell_a_d = idx_q == 2'd3 ? 16'd0 : nxt[0] ? ma_q[31:16] : ma_q[15:0];
        cell_b_d = idx_q == 2'd3 ? 16'd0 : nxt[1] ? mb_q[31:16] : mb_q[15:0];
      end
      ST_DRAIN: begin
        acc_d   = acc_add;
        state_d = (dl_out.v && dl_out.idx == 2'd3) ? ST_FIX : ST_DRAIN;
      end
      default: begin
        result_d = op_q == OP_MUL ? acc_q[31:0] : acc_fix[63:32];
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
    // Abort beats everything, including a simultaneous start in IDLE.
    if (kill) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      cell_a_d = 16'd0;
      cell_b_d = 16'd0;
      for (int i = 0; i < CELL_LATENCY; i++) dl_d[i] = '0;
    end
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      ma_q     <= '0;
      mb_q     <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cell_a_q <= '0;
      cell_b_q <= '0;
      for (int i = 0; i < CELL_LATENCY; i++) dl_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cell_a_q <= cell_a_d;
      cell_b_q <= cell_b_d;
      for (int i = 0; i < CELL_LATENCY; i++) dl_q[i] <= dl_d[i];
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cell_a = cell_a_q;
  assign cell_b = cell_b_q;
endmodule

// File: tb/tb_mul_hi_sequencer.sv
// tb_mul_hi_sequencer: directed vector table plus kill/reset/busy-restart sequences
module tb_mul_hi_sequencer;
  logic        clk = 0, reset_n = 0, start = 0, kill = 0;
  logic [1:0]  op = 0;
  logic [31:0] src1 = 0, src2 = 0, result, cell_p = 0;
  logic        busy, done;
  logic [15:0] cell_a, cell_b;
  int          checks = 0, fails = 0;

  mul_hi_sequencer #(.CELL_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .op(op),
    .src1(src1), .src2(src2), .busy(busy), .done(done), .result(result),
    .cell_a(cell_a), .cell_b(cell_b), .cell_p(cell_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cell_p <= 32'(cell_a) * 32'(cell_b);

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic b1);
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1;
    @(posedge clk);
    #1 start = 0;
    b1  = busy;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    res = result;
  endtask

  initial begin
    vec_t        vecs [11];
    int          lat, dones;
    logic [31:0] res, old;
    logic        b1;
    vecs[0]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{2'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[4]  = '{2'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
    vecs[5]  = '{2'd0, 32'h00010003, 32'h00020005, 32'h000B000F};
    vecs[6]  = '{2'd3, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[7]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[8]  = '{2'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[9]  = '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000};
    vecs[10] = '{2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cell_a", cell_a, 0);
    chk("rst_cell_b", cell_b, 0);
    @(negedge clk) reset_n = 1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, b1);
      chk($sformatf("v%0d_busy", i), b1, 1);
      chk($sformatf("v%0d_latency", i), lat, 6);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_idle_at_done", i), busy, 0);
    end

    // start pulsed again mid-operation is ignored
    @(negedge clk);
    op = 2'd0; src1 = 32'h00010003; src2 = 32'h00020005; start = 1;
    @(posedge clk);
    #1 start = 0;
    dones = 0; lat = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 2) begin
        start = 1; op = 2'd3; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
      end else start = 0;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (lat == 0) lat = n;
      end
    end
    chk("busy_start_dones", dones, 1);
    chk("busy_start_latency", lat, 6);
    chk("busy_start_result", result, 32'h000B000F);
    repeat (3) @(posedge clk);
    #1 chk("result_held", result, 32'h000B000F);

    // kill on third ISSUE cycle
    old = result;
    @(negedge clk);
    op = 2'd3; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("issue0_cell_a", cell_a, 16'hFFFF);
    chk("issue0_cell_b", cell_b, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 kill = 1;
    @(posedge clk);
    #1 kill = 0;
    chk("kill_busy", busy, 0);
    chk("kill_cell_a", cell_a, 0);
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("kill_no_done", dones, 0);
    chk("kill_result", result, old);

    // kill and start together in IDLE
    @(negedge clk);
    op = 2'd3; src1 = 32'h12345678; src2 = 32'h9ABCDEF0; start = 1; kill = 1;
    @(posedge clk);
    #1 begin start = 0; kill = 0; end
    chk("kill_start_busy", busy, 0);
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("kill_start_no_done", dones, 0);
    chk("kill_start_result", result, old);

    // asynchronous reset during DRAIN
    @(negedge clk);
    op = 2'd3; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1 chk("drain_busy", busy, 1);
    reset_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_cell_a", cell_a, 0);
    chk("arst_cell_b", cell_b, 0);
    @(negedge clk) reset_n = 1;
    run_op(2'd3, 32'h00010000, 32'h00010000, lat, res, b1);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_result", res, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
